// File: rtl/switch_feed_delay_if.sv
// ---------------------------------------------------------------------------
// switch_feed_delay_if
//
// Purpose : Bundles the beat-qualified input lanes and registered output lanes
//           of switch_feed_delay into one connection.
//
// Signals : in_valid   beat qualifier from upstream
//           in_sop     start of frame, realigns the ctrl phase
//           inData_0   lane 0 input word
//           inData_1   lane 1 input word
//           outData_0  lane 0 towards the switch
//           outData_1  delayed lane 1 towards the switch
//           ctrl       switch control (0 = pass, 1 = cross)
//           out_valid  outputs carry a primed beat this cycle
//
// Modports: master  upstream side (drives the inputs, observes the outputs)
//           slave   the feeder itself
// ---------------------------------------------------------------------------
interface switch_feed_delay_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_sop;
    logic [DATA_WIDTH-1:0] inData_0;
    logic [DATA_WIDTH-1:0] inData_1;
    logic [DATA_WIDTH-1:0] outData_0;
    logic [DATA_WIDTH-1:0] outData_1;
    logic                  ctrl;
    logic                  out_valid;

    modport master (
        output in_valid, in_sop, inData_0, inData_1,
        input  outData_0, outData_1, ctrl, out_valid
    );

    modport slave (
        input  in_valid, in_sop, inData_0, inData_1,
        output outData_0, outData_1, ctrl, out_valid
    );
endinterface

// File: rtl/switch_feed_delay.sv
// ---------------------------------------------------------------------------
// switch_feed_delay
//
// Purpose : Feeder for the 2x2 registered switch of the streaming NTT
//           permutation network. Lane 0 passes through one register stage,
//           lane 1 is delayed by DELAY valid beats, and the switch ctrl bit
//           toggles every DELAY beats. All outputs are registered.
//
// Ports   : clk   clock
//           rst   synchronous, active-high reset
//           bus   switch_feed_delay_if.slave (lanes, sop, valids, ctrl)
//
// Parameters: DATA_WIDTH  lane word width
//             DELAY       lane-1 delay and ctrl half-period in beats
//                         (power of 2, >= 1)
// ---------------------------------------------------------------------------
module switch_feed_delay #(
    parameter int DATA_WIDTH = 32,
    parameter int DELAY      = 4
) (
    input  logic               clk,
    input  logic               rst,
    switch_feed_delay_if.slave bus
);
    // ctrl is bit CB of the beat counter; the counter spans 2*DELAY beats.
    localparam int CB = $clog2(DELAY);
    localparam int CW = CB + 1;
    localparam int FW = $clog2(DELAY + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DELAY);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t         dl_q [DELAY];
    word_t         dl_d [DELAY];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fill_q, fill_d;
    word_t         out_data_0_q, out_data_0_d;
    word_t         out_data_1_q, out_data_1_d;
    logic          ctrl_q, ctrl_d;
    logic          out_valid_q, out_valid_d;

    logic [CW-1:0] c_eff;
    logic          primed;

    always_comb begin
        // NOTE: every combinational output gets a hold/default value first so
        // that no path through the if leaves it unassigned (no latches).
        dl_d         = dl_q;
        cnt_d        = cnt_q;
        fill_d       = fill_q;
        out_data_0_d = out_data_0_q;
        out_data_1_d = out_data_1_q;
        ctrl_d       = ctrl_q;
        out_valid_d  = 1'b0;

        // sop realigns the ctrl phase on its own beat, not the next one.
        c_eff  = bus.in_sop ? '0 : cnt_q;
        primed = (fill_q == FILL_MAX);

        if (bus.in_valid) begin
            // Oldest entry (index DELAY-1) is the lane-1 word from DELAY beats ago.
            dl_d[0] = bus.inData_1;
            for (int i = 1; i < DELAY; i++) begin
                dl_d[i] = dl_q[i-1];
            end
            cnt_d        = c_eff + CW'(1);
            if (!primed) begin
                fill_d = fill_q + FW'(1);
            end
            out_data_0_d = bus.inData_0;
            out_data_1_d = dl_q[DELAY-1];
            ctrl_d       = c_eff[CB];
            out_valid_d  = primed;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the values from before this edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the delay line is reset too: its zero contents are what
            // outData_1 shows during priming, and reset must drop stale words.
            dl_q         <= '{default: '0};
            cnt_q        <= '0;
            fill_q       <= '0;
            out_data_0_q <= '0;
            out_data_1_q <= '0;
            ctrl_q       <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            dl_q         <= dl_d;
            cnt_q        <= cnt_d;
            fill_q       <= fill_d;
            out_data_0_q <= out_data_0_d;
            out_data_1_q <= out_data_1_d;
            ctrl_q       <= ctrl_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign bus.outData_0 = out_data_0_q;
    assign bus.outData_1 = out_data_1_q;
    assign bus.ctrl      = ctrl_q;
    assign bus.out_valid = out_valid_q;

endmodule
